// File: rtl/mmu_input_feeder.sv
// mmu_input_feeder
//   Streams input vectors from the activation buffer into the left edge of the
//   systolic MMU. One vector is read per cycle. Each row of the vector is then
//   delayed diagonally: row r is delayed r cycles more than row 0. A valid bit
//   travels with the data and drives the PE row's active input.
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   start           1-cycle pulse that begins a feed job (honoured only when idle)
//   base_addr       address of the first vector, latched on start
//   num_vectors     number of vectors to feed (0 allowed), latched on start
//   mem_rd_en       activation buffer read strobe
//   mem_addr        activation buffer read address
//   mem_rdata       read data, valid the cycle after mem_rd_en
//   datain_out      lane r drives PE row r; the lane is zero while that row is inactive
//   active_out      bit r is the active flag for PE row r
//   busy            high while a job is in progress, including the done cycle
//   done            1-cycle pulse once the last vector has left the skew pipeline
module mmu_input_feeder #(
    parameter int unsigned ARRAY_DIM = 8,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned ADDR_W    = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [ADDR_W-1:0]             base_addr,
    input  logic [ADDR_W-1:0]             num_vectors,
    output logic                          mem_rd_en,
    output logic [ADDR_W-1:0]             mem_addr,
    input  logic [ARRAY_DIM*DATA_W-1:0]   mem_rdata,
    output logic [ARRAY_DIM*DATA_W-1:0]   datain_out,
    output logic [ARRAY_DIM-1:0]          active_out,
    output logic                          busy,
    output logic                          done
);

    localparam int unsigned DCNT_W = $clog2(ARRAY_DIM + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        state_q,  state_d;
    logic [ADDR_W-1:0] num_q,    num_d;
    logic [ADDR_W-1:0] idx_q,    idx_d;
    logic [DCNT_W-1:0] dcnt_q,   dcnt_d;
    logic              rd_en_q,  rd_en_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic              busy_q,   busy_d;
    logic              done_q,   done_d;
    logic              rvalid_q, rvalid_d;

    // Next-state and registered-output logic of the job controller.
    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        idx_d   = idx_q;
        dcnt_d  = dcnt_q;
        rd_en_d = 1'b0;
        addr_d  = '0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    num_d = num_vectors;
                    if (num_vectors != '0) begin
                        state_d = S_FETCH;
                        rd_en_d = 1'b1;
                        addr_d  = base_addr;
                        idx_d   = '0;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            // idx_q is the index of the read currently on the bus.
            S_FETCH: begin
                if (idx_q == ADDR_W'(num_q - ADDR_W'(1))) begin
                    state_d = S_DRAIN;
                    dcnt_d  = '0;
                end else begin
                    idx_d   = ADDR_W'(idx_q + ADDR_W'(1));
                    rd_en_d = 1'b1;
                    addr_d  = ADDR_W'(addr_q + ADDR_W'(1));
                end
            end
            // Wait for the last read to reach the deepest row: ARRAY_DIM+1 cycles.
            S_DRAIN: begin
                if (dcnt_q == DCNT_W'(ARRAY_DIM)) begin
                    state_d = S_DONE;
                end else begin
                    dcnt_d = DCNT_W'(dcnt_q + DCNT_W'(1));
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d   = (state_d != S_IDLE);
        done_d   = (state_d == S_DONE);
        rvalid_d = rd_en_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            num_q    <= '0;
            idx_q    <= '0;
            dcnt_q   <= '0;
            rd_en_q  <= 1'b0;
            addr_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            num_q    <= num_d;
            idx_q    <= idx_d;
            dcnt_q   <= dcnt_d;
            rd_en_q  <= rd_en_d;
            addr_q   <= addr_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign mem_rd_en = rd_en_q;
    assign mem_addr  = addr_q;
    assign busy      = busy_q;
    assign done      = done_q;

    // Per-row skew pipeline: row r has r+1 stages. Data is zeroed on entry when
    // not valid, so every stage holds zero whenever its valid bit is low.
    for (genvar r = 0; r < int'(ARRAY_DIM); r++) begin : g_row
        logic [r:0]             v_q, v_d;
        logic [DATA_W-1:0]      d_q [r+1];
        logic [DATA_W-1:0]      d_d [r+1];

        always_comb begin
            v_d[0] = rvalid_q;
            d_d[0] = rvalid_q ? mem_rdata[r*DATA_W +: DATA_W] : '0;
            for (int s = 1; s <= r; s++) begin
                v_d[s] = v_q[s-1];
                d_d[s] = d_q[s-1];
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                v_q <= '0;
                for (int s = 0; s <= r; s++) begin
                    d_q[s] <= '0;
                end
            end else begin
                v_q <= v_d;
                for (int s = 0; s <= r; s++) begin
                    d_q[s] <= d_d[s];
                end
            end
        end

        assign active_out[r]                 = v_q[r];
        assign datain_out[r*DATA_W +: DATA_W] = d_q[r];
    end

endmodule
